ext_feedback_stage: RTL and testbench

EXT_FEEDBACK_STAGE -- requirements
Module: ext_feedback_stage

---
 rtl/fptd_pkg.sv | 17 +
 rtl/ext_feedback_stage_bitclip.sv | 26 ++
 rtl/ext_feedback_stage.sv | 117 +++++++++++
 tb/tb_ext_feedback_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fptd_pkg.sv
// Shared definitions for the turbo-decoder feedback path: default widths and
// the extrinsic feedback stage state encoding.
package fptd_pkg;

  localparam int M_DEF          = 6;
  localparam int N_DEF          = 5;
  localparam int HALF_ITERS_DEF = 16;
  localparam int E_DEF          = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2,
    ST_DONE    = 2'd3
  } fb_state_e;

endpackage

// File: rtl/ext_feedback_stage_bitclip.sv
// BitClip: signed saturation from N_In bits down to N_Out bits
// (clips to [-2^(N_Out-1), 2^(N_Out-1)-1]); requires N_In >= N_Out.
module BitClip #(
  parameter int N_In  = 7,
  parameter int N_Out = 5
) (
  input  logic signed [N_In-1:0]  din,
  output logic signed [N_Out-1:0] dout
);

  localparam logic signed [N_In-1:0] MAX_V = N_In'((2 ** (N_Out - 1)) - 1);
  localparam logic signed [N_In-1:0] MIN_V = N_In'(-(2 ** (N_Out - 1)));

  // Clip to the output range, otherwise pass the low bits through unchanged
  always_comb begin
    dout = din[N_Out-1:0];
    if (din > MAX_V) begin
      dout = MAX_V[N_Out-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[N_Out-1:0];
    end else begin
      dout = din[N_Out-1:0];
    end
  end

endmodule

// File: rtl/ext_feedback_stage.sv
// Extrinsic feedback stage: scales and saturates the Razor-protected extrinsic
// LLR into the next half-iteration's a-priori value, with one-cycle recovery.
module ext_feedback_stage
  import fptd_pkg::*;
#(
  parameter int M          = M_DEF,
  parameter int N          = N_DEF,
  parameter int HALF_ITERS = HALF_ITERS_DEF,
  parameter int E          = E_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic signed [M-1:0] be1_in,
  input  logic                Error_in,
  output logic signed [N-1:0] ba2_out,
  output logic                Stall,
  output logic                Busy,
  output logic                Done,
  output logic                Hard,
  output logic [E-1:0]        Err_count
);

  localparam int            CW       = $clog2(HALF_ITERS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF_ITERS - 1);
  localparam logic [E-1:0]  ERR_MAX  = {E{1'b1}};

  fb_state_e            state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic signed [N-1:0]  ba2_r, ba2_s;
  logic [E-1:0]         err_r, err_s;
  logic signed [M:0]    ext_s;
  logic signed [M:0]    scaled_s;
  logic signed [N-1:0]  clip_s;

  // 0.75 scaling with floor shifts; M+1 bits cannot overflow for any M-bit input
  always_comb begin
    ext_s    = {be1_in[M-1], be1_in};
    scaled_s = (ext_s >>> 1) + (ext_s >>> 2);
  end

  BitClip #(
    .N_In  (M + 1),
    .N_Out (N)
  ) u_clip (
    .din  (scaled_s),
    .dout (clip_s)
  );

  // Next-state logic; RECOVER accepts unconditionally, so Error_in is ignored there
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ba2_s   = ba2_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s = ST_RUN;
          cnt_s   = '0;
          ba2_s   = '0;
          err_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Error_in) begin
          state_s = ST_RECOVER;
          if (err_r != ERR_MAX) begin
            err_s = err_r + E'(1);
          end else begin
            err_s = err_r;
          end
        end else begin
          ba2_s   = clip_s;
          cnt_s   = cnt_r + CW'(1);
          state_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_RUN;
        end
      end
      ST_RECOVER: begin
        ba2_s   = clip_s;
        cnt_s   = cnt_r + CW'(1);
        state_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ba2_r   <= '0;
      err_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ba2_r   <= ba2_s;
      err_r   <= err_s;
    end
  end

  assign ba2_out   = ba2_r;
  assign Err_count = err_r;
  assign Stall     = (state_r == ST_RECOVER);
  assign Busy      = (state_r == ST_RUN) || (state_r == ST_RECOVER);
  assign Done      = (state_r == ST_DONE);
  assign Hard      = (state_r == ST_DONE) && ba2_r[N-1];

endmodule

// File: tb/tb_ext_feedback_stage.sv
// Scoreboard bench for ext_feedback_stage: the driver queues hand-computed
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_ext_feedback_stage;

  logic              Clock;
  logic              Reset;
  logic              Start;
  logic signed [5:0] be1_in;
  logic              Error_in;
  logic signed [4:0] ba2_out;
  logic              Stall;
  logic              Busy;
  logic              Done;
  logic              Hard;
  logic [1:0]        Err_count;

  ext_feedback_stage #(
    .M          (6),
    .N          (5),
    .HALF_ITERS (16),
    .E          (2)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .be1_in    (be1_in),
    .Error_in  (Error_in),
    .ba2_out   (ba2_out),
    .Stall     (Stall),
    .Busy      (Busy),
    .Done      (Done),
    .Hard      (Hard),
    .Err_count (Err_count)
  );

  typedef struct {
    int                cyc;
    logic signed [4:0] ba2;
    logic              stall;
    logic              busy;
    logic              done;
    logic              hard;
    logic [1:0]        errc;
    string             tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic test_done = 1'b0;

  // Input vectors and hand-computed sat5((x>>>1)+(x>>>2))
  logic signed [5:0] vin[16]  = '{6'sd10, 6'sd31, -6'sd32, -6'sd3, 6'sd0, 6'sd1, -6'sd1, 6'sd2,
                                  6'sd4, -6'sd4, 6'sd7, -6'sd8, 6'sd12, 6'sd20, -6'sd20, -6'sd6};
  logic signed [4:0] vexp[16] = '{5'sd7, 5'sd15, -5'sd16, -5'sd3, 5'sd0, 5'sd0, -5'sd2, 5'sd1,
                                  5'sd3, -5'sd3, 5'sd4, -5'sd6, 5'sd9, 5'sd15, -5'sd15, -5'sd5};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

  always @(negedge Clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      mon_e = q.pop_front();
      n_checks++;
      if (ba2_out !== mon_e.ba2 || Stall !== mon_e.stall || Busy !== mon_e.busy ||
          Done !== mon_e.done || Hard !== mon_e.hard || Err_count !== mon_e.errc) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got ba2=%0d stall=%b busy=%b done=%b hard=%b errc=%0d want ba2=%0d stall=%b busy=%b done=%b hard=%b errc=%0d",
                 mon_e.tag, cyc_cnt, ba2_out, Stall, Busy, Done, Hard, Err_count,
                 mon_e.ba2, mon_e.stall, mon_e.busy, mon_e.done, mon_e.hard, mon_e.errc);
      end
    end
  end

  initial begin
    #100000;
    if (!test_done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic step(input logic rst, input logic st, input logic signed [5:0] be, input logic er,
                      input logic signed [4:0] eb, input logic es, input logic ebz, input logic ed,
                      input logic eh, input logic [1:0] ec, input string tag);
    exp_t x;
    Reset    = rst;
    Start    = st;
    be1_in   = be;
    Error_in = er;
    x.cyc   = cyc_cnt + 1;
    x.ba2   = eb;
    x.stall = es;
    x.busy  = ebz;
    x.done  = ed;
    x.hard  = eh;
    x.errc  = ec;
    x.tag   = tag;
    q.push_back(x);
    @(posedge Clock);
    #1;
  endtask

  // One frame; mask bit i puts a Razor error just before accept i, abort_at<16 resets there
  task automatic run_frame(input logic [15:0] mask, input int abort_at, input string nm);
    logic signed [4:0] ba;
    logic [1:0]        ec;
    logic              last;
    ba = 5'sd0;
    ec = 2'd0;
    step(1'b0, 1'b1, 6'sd0, 1'b0, ba, 1'b0, 1'b1, 1'b0, 1'b0, ec, {nm, "_start"});
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'b1, vin[i], 1'b1, 5'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, {nm, "_midreset"});
        return;
      end
      last = (i == 15);
      if (mask[i]) begin
        if (ec != 2'd3) ec = ec + 2'd1;
        step(1'b0, 1'b1, vin[15-i], 1'b1, ba, 1'b1, 1'b1, 1'b0, 1'b0, ec, {nm, "_err"});
        ba = vexp[i];
        step(1'b0, 1'b1, vin[i], 1'b1, ba, 1'b0, !last, last, last & ba[4], ec, {nm, "_recover"});
      end else begin
        ba = vexp[i];
        step(1'b0, (i == 4), vin[i], 1'b0, ba, 1'b0, !last, last, last & ba[4], ec, {nm, "_accept"});
      end
    end
    step(1'b0, 1'b1, 6'sd0, 1'b0, ba, 1'b0, 1'b0, 1'b0, 1'b0, ec, {nm, "_start_in_done"});
    step(1'b0, 1'b0, 6'sd0, 1'b0, ba, 1'b0, 1'b0, 1'b0, 1'b0, ec, {nm, "_idle_hold"});
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    be1_in   = 6'sd0;
    Error_in = 1'b0;
    step(1'b1, 1'b0, 6'sd0, 1'b0, 5'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "reset0");
    step(1'b1, 1'b1, 6'sd5, 1'b1, 5'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_over_start");
    step(1'b0, 1'b0, 6'sd5, 1'b1, 5'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "idle_no_start");
    n_checks++;
    if (ba2_out !== 5'sd0 || Stall !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 ||
        Hard !== 1'b0 || Err_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got ba2=%0d stall=%b busy=%b done=%b hard=%b errc=%0d",
               ba2_out, Stall, Busy, Done, Hard, Err_count);
    end
    run_frame(16'h0000, 16, "clean");
    run_frame(16'h0008, 16, "one_err");
    run_frame(16'hFFFF, 16, "err_sat");
    run_frame(16'h8000, 16, "err_last");
    run_frame(16'h0000, 7, "abort");
    step(1'b0, 1'b0, 6'sd9, 1'b0, 5'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "post_abort_idle");
    run_frame(16'h0000, 16, "after_abort");
    @(negedge Clock);
    #1;
    test_done = 1'b1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %0d expected entries never compared", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
